uart_tx_arbiter: RTL

//   Shares one UART transmitter among NUM_REQ byte sources. Round-robin grant per packet;
//   a granted source streams bytes (valid/ready) until it flags last, hits MAX_BURST, or stalls

---
 rtl/uart_tx_arbiter_if.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - byte-source and transmitter handshake bundle for uart_tx_arbiter
//
// Purpose : groups the per-source byte streams, the transmitter load/status
//           strobes and the grant status into one interface.
// Signals : req_valid/req_data/req_last  per-source byte stream (source i at [8*i+7:8*i])
//           req_ready                    per-source accept strobe (at most one bit high)
//           tx_start/tx_data             transmitter load pulse and byte
//           tx_busy/tx_done              transmitter status and frame-complete pulse
//           grant_id/grant_active        current/last grant and hold flag
// Modports: master = the arbiter, slave = sources plus transmitter environment.

interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic [GRANT_W-1:0]   grant_id;
    logic                 grant_active;

    modport master (
        input  req_valid, req_data, req_last, tx_busy, tx_done,
        output req_ready, tx_start, tx_data, grant_id, grant_active
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, grant_active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte sources
//
// Purpose : grants the transmitter to one source per packet in round-robin order.
//           The granted source streams bytes until it flags last, reaches
//           MAX_BURST bytes, or holds valid low for HOLD_TIMEOUT cycles.
// Ports   : clk    system clock
//           rst_n  asynchronous active-low reset
//           bus    uart_tx_arbiter_if.master (source streams, transmitter strobes, grant status)
// Params  : NUM_REQ (>=2), GRANT_W = clog2(NUM_REQ), MAX_BURST (1..255), HOLD_TIMEOUT (1..255)

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GRANT_W      = 2,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic [7:0]         BURST_LIMIT = 8'(MAX_BURST);
    // Release fires on the cycle the counter would reach HOLD_TIMEOUT, so the
    // grant drops exactly HOLD_TIMEOUT cycles after SEND is entered.
    localparam logic [7:0]         STALL_LAST  = 8'(HOLD_TIMEOUT - 1);
    localparam logic [GRANT_W-1:0] GRANT_RST   = GRANT_W'(NUM_REQ - 1);

    state_e             state_q,        state_d;
    logic [GRANT_W-1:0] grant_id_q,     grant_id_d;
    logic               grant_active_q, grant_active_d;
    logic [7:0]         burst_cnt_q,    burst_cnt_d;
    logic [7:0]         stall_cnt_q,    stall_cnt_d;
    logic [7:0]         tx_data_q,      tx_data_d;
    logic               tx_start_q,     tx_start_d;
    logic               last_q,         last_d;

    logic               g_valid;
    logic               g_last;
    logic [7:0]         g_data;
    logic               accept;
    logic               pick_found;
    logic [GRANT_W-1:0] pick_id;
    logic [NUM_REQ-1:0] req_ready_w;

    // View of the currently granted source.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id_q == GRANT_W'(j)) begin
                g_valid = bus.req_valid[j];
                g_last  = bus.req_last[j];
                g_data  = bus.req_data[8*j +: 8];
            end
        end
    end

    assign accept = (state_q == ST_SEND) && g_valid && !bus.tx_busy;

    // Round-robin search starting one past the last grant. Offsets are walked
    // from the farthest to the nearest so the nearest valid source is the
    // final assignment and wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = grant_id_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(grant_id_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j == idx) && bus.req_valid[j]) begin
                    pick_found = 1'b1;
                    pick_id    = GRANT_W'(j);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            grant_id_q     <= GRANT_RST;
            grant_active_q <= 1'b0;
            burst_cnt_q    <= 8'h00;
            stall_cnt_q    <= 8'h00;
            tx_data_q      <= 8'h00;
            tx_start_q     <= 1'b0;
            last_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            burst_cnt_q    <= burst_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            last_q         <= last_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        burst_cnt_d    = burst_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        tx_data_d      = tx_data_q;
        tx_start_d     = 1'b0;
        last_d         = last_q;

        case (state_q)
            ST_IDLE: begin
                grant_active_d = 1'b0;
                if (pick_found) begin
                    grant_id_d     = pick_id;
                    grant_active_d = 1'b1;
                    burst_cnt_d    = 8'h00;
                    stall_cnt_d    = 8'h00;
                    state_d        = ST_SEND;
                end
            end

            ST_SEND: begin
                if (accept) begin
                    tx_data_d   = g_data;
                    tx_start_d  = 1'b1;
                    last_d      = g_last;
                    burst_cnt_d = burst_cnt_q + 8'h01;
                    stall_cnt_d = 8'h00;
                    state_d     = ST_WAIT;
                end else if (!g_valid && !bus.tx_busy) begin
                    // A stalled source only burns hold time while the
                    // transmitter could actually take a byte.
                    if (stall_cnt_q == STALL_LAST) begin
                        // grant_id is kept so the next search starts after it.
                        stall_cnt_d    = 8'h00;
                        grant_active_d = 1'b0;
                        state_d        = ST_IDLE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 8'h01;
                    end
                end
            end

            ST_WAIT: begin
                if (bus.tx_done) begin
                    if (last_q || (burst_cnt_q == BURST_LIMIT)) begin
                        grant_active_d = 1'b0;
                        state_d        = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end

            default: begin
                grant_active_d = 1'b0;
                state_d        = ST_IDLE;
            end
        endcase
    end

    // Outputs: accept strobe is combinational, everything else registered.
    always_comb begin
        req_ready_w = '0;
        if ((state_q == ST_SEND) && !bus.tx_busy) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (grant_id_q == GRANT_W'(j)) begin
                    req_ready_w[j] = bus.req_valid[j];
                end
            end
        end
    end

    assign bus.req_ready    = req_ready_w;
    assign bus.tx_start     = tx_start_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.grant_active = grant_active_q;

endmodule
